// File: rtl/mips_register_writeback.sv
// MEM/WB stage register plus the 32x32 register file.
// One instruction is held in the stage. Its write address and write data are
// resolved from the held fields. Each held instruction commits to the array
// at most once, even while the stage is stalled. Both decode read ports see
// the pending write in the same cycle (write-through bypass).
//
// Handshake: in_valid qualifies in_* on any edge where stall is low. While
// stall is high the stage holds and in_* are ignored. flush kills whatever
// the stage would hold after the edge. There is no ready signal; the
// producer owns stall.
module mips_register_writeback #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] in_rt,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_alu,
  input  logic [DATA_WIDTH-1:0] in_mem,
  input  logic [1:0]            in_load_size,
  input  logic                  in_load_signed,
  input  logic [1:0]            in_write_addr_src,
  input  logic [1:0]            in_write_data_src,
  input  logic                  in_write_enable,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  input  logic [ADDR_WIDTH-1:0] rd2_addr,
  output logic [DATA_WIDTH-1:0] rd1_data,
  output logic [DATA_WIDTH-1:0] rd2_data,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  wb_valid
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  localparam logic [1:0] ASRC_RD  = 2'd1;
  localparam logic [1:0] ASRC_R31 = 2'd2;
  localparam logic [1:0] DSRC_MEM = 2'd1;
  localparam logic [1:0] DSRC_PC  = 2'd2;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_BYTE = 2'd2;

  // Held stage fields
  logic [ADDR_WIDTH-1:0] s_rt, s_rd;
  logic [DATA_WIDTH-1:0] s_pc, s_alu, s_mem;
  logic [1:0]            s_load_size, s_addr_src, s_data_src;
  logic                  s_load_signed, s_write_enable;
  logic                  committed;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] lane;
  logic [7:0]            byte_val;
  logic [15:0]           half_val;
  logic                  pending;

  // Stage register: capture, hold, flush, and the committed flag
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid       <= 1'b0;
      committed      <= 1'b0;
      s_rt           <= '0;
      s_rd           <= '0;
      s_pc           <= '0;
      s_alu          <= '0;
      s_mem          <= '0;
      s_load_size    <= '0;
      s_load_signed  <= 1'b0;
      s_addr_src     <= '0;
      s_data_src     <= '0;
      s_write_enable <= 1'b0;
    end else if (!stall) begin
      wb_valid       <= in_valid & ~flush;
      committed      <= 1'b0;
      s_rt           <= in_rt;
      s_rd           <= in_rd;
      s_pc           <= in_pc;
      s_alu          <= in_alu;
      s_mem          <= in_mem;
      s_load_size    <= in_load_size;
      s_load_signed  <= in_load_signed;
      s_addr_src     <= in_write_addr_src;
      s_data_src     <= in_write_data_src;
      s_write_enable <= in_write_enable;
    end else begin
      if (flush) wb_valid <= 1'b0;
      if (pending) committed <= 1'b1;
    end
  end

  // Write address and load-lane extraction
  always_comb begin
    wr_addr = s_rt;
    case (s_addr_src)
      ASRC_RD:  wr_addr = s_rd;
      ASRC_R31: wr_addr = ADDR_WIDTH'(NUM_REGS - 1);
      default:  wr_addr = s_rt;
    endcase
    lane     = s_mem >> {s_alu[1:0], 3'b000};
    byte_val = lane[7:0];
    half_val = s_alu[1] ? s_mem[31:16] : s_mem[15:0];
  end

  // Write data select, including sub-word zero/sign extension
  always_comb begin
    wr_data = s_alu;
    case (s_data_src)
      DSRC_PC:  wr_data = s_pc + DATA_WIDTH'(8);
      DSRC_MEM: begin
        case (s_load_size)
          SIZE_HALF: wr_data = {{16{half_val[15] & s_load_signed}}, half_val};
          SIZE_BYTE: wr_data = {{24{byte_val[7] & s_load_signed}}, byte_val};
          default:   wr_data = s_mem;
        endcase
      end
      default:  wr_data = s_alu;
    endcase
  end

  // Pending-write detection and forward outputs; a write in a reset cycle is dropped
  always_comb begin
    pending   = wb_valid & s_write_enable & (wr_addr != '0) & ~committed & ~reset;
    fwd_valid = pending;
    fwd_addr  = pending ? wr_addr : '0;
    fwd_data  = pending ? wr_data : '0;
  end

  // Register array: optional clear on reset, one write per pending cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      if (CLEAR_ON_RST != 0) begin
        for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end
    end else if (pending) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: r0 is hard zero, pending write bypasses the array
  always_comb begin
    rd1_data = regs[rd1_addr];
    rd2_data = regs[rd2_addr];
    if (rd1_addr == '0) rd1_data = '0;
    else if (fwd_valid && rd1_addr == fwd_addr) rd1_data = fwd_data;
    if (rd2_addr == '0) rd2_data = '0;
    else if (fwd_valid && rd2_addr == fwd_addr) rd2_data = fwd_data;
  end

endmodule

// File: tb/tb_mips_register_writeback.sv
// Bench for mips_register_writeback: reset checks, table of single writes,
// directed stall/flush/reset/back-to-back sequences, random run vs model.
module tb_mips_register_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, stall, flush;
  logic [4:0]  in_rt, in_rd;
  logic [31:0] in_pc, in_alu, in_mem;
  logic [1:0]  in_load_size;
  logic        in_load_signed;
  logic [1:0]  in_write_addr_src, in_write_data_src;
  logic        in_write_enable;
  logic [4:0]  rd1_addr, rd2_addr;
  logic [31:0] rd1_data, rd2_data;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        wb_valid;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mips_register_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CLEAR_ON_RST(1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .in_rt(in_rt), .in_rd(in_rd), .in_pc(in_pc), .in_alu(in_alu), .in_mem(in_mem),
    .in_load_size(in_load_size), .in_load_signed(in_load_signed),
    .in_write_addr_src(in_write_addr_src), .in_write_data_src(in_write_data_src),
    .in_write_enable(in_write_enable), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(rd1_data), .rd2_data(rd2_data), .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .wb_valid(wb_valid)
  );

  // clock / watchdog
  always #5 clock = ~clock;
  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  asrc, dsrc;
    logic [4:0]  rt, rd;
    logic [31:0] pc, alu, mem;
    logic [1:0]  size;
    logic        sgn, we;
    logic [4:0]  exp_addr;
    logic        exp_fwd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    in_rt = '0; in_rd = '0; in_pc = '0; in_alu = '0; in_mem = '0;
    in_load_size = '0; in_load_signed = 1'b0;
    in_write_addr_src = '0; in_write_data_src = '0; in_write_enable = 1'b0;
  endtask

  task automatic drive_op(input vec_t v);
    in_valid = 1'b1;
    in_rt = v.rt; in_rd = v.rd; in_pc = v.pc; in_alu = v.alu; in_mem = v.mem;
    in_load_size = v.size; in_load_signed = v.sgn;
    in_write_addr_src = v.asrc; in_write_data_src = v.dsrc; in_write_enable = v.we;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    drive_idle(); reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  function automatic vec_t alu_wr(input logic [4:0] rd, input logic [31:0] alu);
    vec_t v;
    v = '{asrc:2'd1, dsrc:2'd0, rt:5'd0, rd:rd, pc:32'd0, alu:alu, mem:32'd0,
          size:2'd0, sgn:1'b0, we:1'b1, exp_addr:rd, exp_fwd:1'b1, exp_data:alu};
    return v;
  endfunction

  // Reference: write data from the spec's rules with plain arithmetic
  function automatic logic [31:0] ref_data(input vec_t v);
    logic [31:0] x;
    int off;
    off = int'(v.alu % 4);
    if (v.dsrc == 2'd2) return v.pc + 32'd8;
    if (v.dsrc != 2'd1) return v.alu;
    if (v.size == 2'd2) begin
      x = (v.mem >> (8 * off)) % 256;
      if (v.sgn && x >= 128) x = x - 256;
      return x;
    end
    if (v.size == 2'd1) begin
      x = (off >= 2) ? (v.mem >> 16) : (v.mem % 65536);
      if (v.sgn && x >= 32768) x = x - 65536;
      return x;
    end
    return v.mem;
  endfunction

  function automatic logic [4:0] ref_addr(input vec_t v);
    if (v.asrc == 2'd1) return v.rd;
    if (v.asrc == 2'd2) return 5'd31;
    return v.rt;
  endfunction

  // model state for the random phase
  logic [31:0] m_regs [32];
  vec_t        m_stage;
  logic        m_valid, m_comm;

  initial begin
    vec_t v;
    int cnt;
    logic        m_pend;
    logic [4:0]  m_a;
    logic [31:0] m_d, e1, e2;

    //                asrc  dsrc  rt     rd     pc             alu            mem            sz    sg    we    ea     ef    ed
    vecs[0]  = '{2'd1, 2'd0, 5'd0,  5'd9,  32'h0,         32'h1234_5678, 32'h0,         2'd0, 1'b0, 1'b1, 5'd9,  1'b1, 32'h1234_5678};
    vecs[1]  = '{2'd2, 2'd2, 5'd1,  5'd2,  32'h0040_0010, 32'h0,         32'h0,         2'd0, 1'b0, 1'b1, 5'd31, 1'b1, 32'h0040_0018};
    vecs[2]  = '{2'd2, 2'd2, 5'd1,  5'd2,  32'hFFFF_FFFC, 32'h0,         32'h0,         2'd0, 1'b0, 1'b1, 5'd31, 1'b1, 32'h0000_0004};
    vecs[3]  = '{2'd0, 2'd1, 5'd3,  5'd0,  32'h0,         32'h3,         32'h80FF_7F01, 2'd2, 1'b1, 1'b1, 5'd3,  1'b1, 32'hFFFF_FF80};
    vecs[4]  = '{2'd0, 2'd1, 5'd4,  5'd0,  32'h0,         32'h0,         32'h80FF_7F01, 2'd2, 1'b0, 1'b1, 5'd4,  1'b1, 32'h0000_0001};
    vecs[5]  = '{2'd0, 2'd1, 5'd6,  5'd0,  32'h0,         32'h2,         32'h80FF_7F01, 2'd1, 1'b1, 1'b1, 5'd6,  1'b1, 32'hFFFF_80FF};
    vecs[6]  = '{2'd0, 2'd1, 5'd8,  5'd0,  32'h0,         32'h0,         32'h80FF_7F01, 2'd0, 1'b0, 1'b1, 5'd8,  1'b1, 32'h80FF_7F01};
    vecs[7]  = '{2'd3, 2'd3, 5'd10, 5'd11, 32'h44,        32'h0000_CAFE, 32'h9999_9999, 2'd0, 1'b0, 1'b1, 5'd10, 1'b1, 32'h0000_CAFE};
    vecs[8]  = '{2'd0, 2'd1, 5'd12, 5'd0,  32'h0,         32'h0,         32'h80FF_7F01, 2'd1, 1'b0, 1'b1, 5'd12, 1'b1, 32'h0000_7F01};
    vecs[9]  = '{2'd0, 2'd1, 5'd13, 5'd0,  32'h0,         32'h1,         32'h80FF_7F01, 2'd2, 1'b1, 1'b1, 5'd13, 1'b1, 32'h0000_007F};
    vecs[10] = '{2'd1, 2'd0, 5'd0,  5'd5,  32'h0,         32'hAAAA_0000, 32'h0,         2'd0, 1'b0, 1'b1, 5'd5,  1'b1, 32'hAAAA_0000};
    vecs[11] = '{2'd1, 2'd0, 5'd0,  5'd0,  32'h0,         32'h7777_7777, 32'h0,         2'd0, 1'b0, 1'b1, 5'd0,  1'b0, 32'h0};

    drive_idle(); reset = 1'b1; rd1_addr = 5'd9; rd2_addr = 5'd31;
    do_reset();
    @(negedge clock);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("rst_fwd_addr", {27'd0, fwd_addr}, 32'd0);
    check("rst_fwd_data", fwd_data, 32'd0);
    check("rst_rd1", rd1_data, 32'd0);
    check("rst_rd2", rd2_data, 32'd0);

    // table of single writes
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      drive_op(vecs[i]);
      rd1_addr = vecs[i].exp_addr; rd2_addr = vecs[i].exp_addr;
      exp_q.push_back(vecs[i].exp_fwd ? vecs[i].exp_data : 32'd0);
      @(posedge clock); #1;
      drive_idle();
      @(negedge clock);
      check($sformatf("v%0d_wb_valid", i), {31'd0, wb_valid}, 32'd1);
      check($sformatf("v%0d_fwd_valid", i), {31'd0, fwd_valid}, {31'd0, vecs[i].exp_fwd});
      check($sformatf("v%0d_fwd_addr", i), {27'd0, fwd_addr},
            vecs[i].exp_fwd ? {27'd0, vecs[i].exp_addr} : 32'd0);
      check($sformatf("v%0d_fwd_data", i), fwd_data, exp_q.pop_front());
      check($sformatf("v%0d_bypass", i), rd1_data, vecs[i].exp_data);
      @(posedge clock); #1;
      @(negedge clock);
      check($sformatf("v%0d_fwd_after", i), {31'd0, fwd_valid}, 32'd0);
      check($sformatf("v%0d_array", i), rd2_data, vecs[i].exp_data);
    end

    // write-enable low leaves the register alone
    @(posedge clock); #1;
    v = alu_wr(5'd20, 32'h5555_5555); v.we = 1'b0;
    drive_op(v); rd1_addr = 5'd20;
    @(posedge clock); #1; drive_idle();
    @(negedge clock);
    check("we0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("we0_array", rd1_data, 32'd0);

    // stall held over a write: one write, fwd high one cycle
    @(posedge clock); #1;
    drive_op(alu_wr(5'd14, 32'h1111_1111)); rd1_addr = 5'd14;
    @(posedge clock); #1;
    drive_idle(); stall = 1'b1;
    cnt = 0;
    repeat (3) begin
      @(negedge clock);
      if (fwd_valid) cnt++;
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("stall_fwd_cycles", cnt, 1);
    check("stall_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("stall_array", rd1_data, 32'h1111_1111);
    // flush while stalled clears the stage
    @(posedge clock); #1;
    flush = 1'b1;
    @(posedge clock); #1;
    stall = 1'b0; flush = 1'b0;
    @(negedge clock);
    check("stflush_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("stflush_fwd_valid", {31'd0, fwd_valid}, 32'd0);

    // flush on the capture edge: no write
    @(posedge clock); #1;
    drive_op(alu_wr(5'd16, 32'h2222_2222)); flush = 1'b1; rd1_addr = 5'd16;
    @(posedge clock); #1; drive_idle();
    @(negedge clock);
    check("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("flush_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("flush_array", rd1_data, 32'd0);

    // reset in the pending-write cycle
    @(posedge clock); #1;
    drive_op(alu_wr(5'd17, 32'h3333_3333)); rd1_addr = 5'd17; rd2_addr = 5'd14;
    @(posedge clock); #1;
    drive_idle(); reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rstpend_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("rstpend_fwd_addr", {27'd0, fwd_addr}, 32'd0);
    check("rstpend_fwd_data", fwd_data, 32'd0);
    check("rstpend_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rstpend_r17", rd1_data, 32'd0);
    check("rstpend_r14_cleared", rd2_data, 32'd0);

    // back-to-back writes to r7
    @(posedge clock); #1;
    drive_op(alu_wr(5'd7, 32'd1)); rd1_addr = 5'd7;
    @(posedge clock); #1;
    drive_op(alu_wr(5'd7, 32'd2));
    @(negedge clock);
    check("b2b_first_fwd", fwd_data, 32'd1);
    @(posedge clock); #1; drive_idle();
    @(negedge clock);
    check("b2b_second_fwd", fwd_data, 32'd2);
    check("b2b_bypass", rd1_data, 32'd2);
    @(posedge clock); #1;
    @(negedge clock);
    check("b2b_final", rd1_data, 32'd2);
    check("b2b_fwd_idle", {31'd0, fwd_valid}, 32'd0);

    // random run against the model
    do_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0; m_comm = 1'b0; m_stage = alu_wr(5'd0, 32'd0);
    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      in_rt = 5'($urandom_range(0, 7)); in_rd = 5'($urandom_range(0, 7));
      in_pc = $urandom; in_alu = $urandom; in_mem = $urandom;
      in_load_size = 2'($urandom_range(0, 3)); in_load_signed = 1'($urandom_range(0, 1));
      in_write_addr_src = 2'($urandom_range(0, 3)); in_write_data_src = 2'($urandom_range(0, 3));
      in_write_enable = ($urandom_range(0, 4) != 0);
      rd1_addr = 5'($urandom_range(0, 7)); rd2_addr = 5'($urandom_range(0, 7));
      @(negedge clock);
      m_a = ref_addr(m_stage);
      m_d = ref_data(m_stage);
      m_pend = m_valid && m_stage.we && (m_a != 0) && !m_comm;
      e1 = (rd1_addr == 0) ? 32'd0 : (m_pend && rd1_addr == m_a) ? m_d : m_regs[rd1_addr];
      e2 = (rd2_addr == 0) ? 32'd0 : (m_pend && rd2_addr == m_a) ? m_d : m_regs[rd2_addr];
      check("rnd_wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
      check("rnd_fwd_valid", {31'd0, fwd_valid}, {31'd0, m_pend});
      check("rnd_fwd_addr", {27'd0, fwd_addr}, m_pend ? {27'd0, m_a} : 32'd0);
      check("rnd_fwd_data", fwd_data, m_pend ? m_d : 32'd0);
      check("rnd_rd1", rd1_data, e1);
      check("rnd_rd2", rd2_data, e2);
      if (m_pend) m_regs[m_a] = m_d;
      if (!stall) begin
        m_stage = '{asrc:in_write_addr_src, dsrc:in_write_data_src, rt:in_rt, rd:in_rd,
                    pc:in_pc, alu:in_alu, mem:in_mem, size:in_load_size, sgn:in_load_signed,
                    we:in_write_enable, exp_addr:5'd0, exp_fwd:1'b0, exp_data:32'd0};
        m_valid = in_valid && !flush;
        m_comm = 1'b0;
      end else begin
        if (flush) m_valid = 1'b0;
        if (m_pend) m_comm = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
